// File: rtl/stack_alu_sequencer_pkg.sv
// stack_alu_pkg: opcodes, token kinds, error codes and FSM states for the stack ALU sequencer
package stack_alu_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  localparam logic [1:0] TK_PUSH = 2'd0;
  localparam logic [1:0] TK_ADD  = 2'd1;
  localparam logic [1:0] TK_MUL  = 2'd2;
  localparam logic [1:0] TK_END  = 2'd3;
  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_FULL   = 2'd1;
  localparam logic [1:0] ERR_UNDER  = 2'd2;
  localparam logic [1:0] ERR_BADEND = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_EXEC, S_CAPTURE, S_DRAIN, S_RESULT
  } state_t;
endpackage

// File: rtl/stack_alu_sequencer_if.sv
// stack_alu_sequencer_if: token stream in, result/error out, both valid/ready
interface stack_alu_sequencer_if #(parameter int N = 16);
  logic         tok_valid;
  logic         tok_ready;
  logic [1:0]   tok_kind;
  logic [N-1:0] tok_data;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_ovf;
  logic [1:0]   res_err;
  modport master (
    output tok_valid, tok_kind, tok_data, res_ready,
    input  tok_ready, res_valid, res_data, res_ovf, res_err
  );
  modport slave (
    input  tok_valid, tok_kind, tok_data, res_ready,
    output tok_ready, res_valid, res_data, res_ovf, res_err
  );
endinterface

// File: rtl/stack_alu_sequencer_tracker.sv
// stack_depth_tracker: mirrors the ALU stack depth from issued push/pop-style opcodes
module stack_depth_tracker #(
  parameter int DEPTH = 16,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] depth,
  output logic          is_full,
  output logic          lt_two
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) depth <= '0;
    else if (inc && !dec) depth <= depth + DW'(1);
    else if (dec && !inc) depth <= depth - DW'(1);
  assign is_full = depth == DW'(DEPTH);
  assign lt_two  = depth < DW'(2);
endmodule

// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: validates an RPN token stream and drives a stack ALU one opcode per cycle
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N = 16,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_alu_sequencer_if.slave bus,
  output logic [2:0]           alu_opcode,
  output logic [N-1:0]         alu_data,
  input  logic [N-1:0]         alu_result,
  input  logic                 alu_ovf,
  input  logic [4:0]           alu_sp
);
  localparam int DW = $clog2(DEPTH + 1);
  state_t state, nxt;
  logic [DW-1:0] depth;
  logic is_full, lt_two, inc, dec, set_err, ovf;
  logic [1:0] err, err_code;
  logic [N-1:0] res_q;
  stack_depth_tracker #(.DEPTH(DEPTH)) u_depth (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec),
    .depth(depth), .is_full(is_full), .lt_two(lt_two)
  );
  always_comb begin
    nxt = state;
    alu_opcode = OP_NOP;
    alu_data = '0;
    inc = 1'b0;
    dec = 1'b0;
    set_err = 1'b0;
    err_code = ERR_OK;
    case (state)
      S_IDLE: nxt = S_ACCEPT;
      S_ACCEPT:
        if (bus.tok_valid)
          case (bus.tok_kind)
            TK_PUSH:
              if (is_full) begin
                set_err = 1'b1;
                err_code = ERR_FULL;
                nxt = S_DRAIN;
              end else begin
                alu_opcode = OP_PUSH;
                alu_data = bus.tok_data;
                inc = 1'b1;
              end
            TK_END:
              if (depth == DW'(1)) begin
                alu_opcode = OP_POP;
                dec = 1'b1;
                nxt = S_CAPTURE;
              end else begin
                set_err = 1'b1;
                err_code = ERR_BADEND;
                nxt = S_DRAIN;
              end
            default:
              if (lt_two) begin
                set_err = 1'b1;
                err_code = ERR_UNDER;
                nxt = S_DRAIN;
              end else begin
                alu_opcode = bus.tok_kind == TK_ADD ? OP_ADD : OP_MUL;
                dec = 1'b1;
                nxt = S_EXEC;
              end
          endcase
      S_EXEC: nxt = S_ACCEPT;
      S_CAPTURE: nxt = S_RESULT;
      S_DRAIN: begin
        // the last pop and the hand-off share a cycle, so N entries drain in N cycles
        alu_opcode = depth != '0 ? OP_POP : OP_NOP;
        dec = depth != '0;
        nxt = depth <= DW'(1) ? S_RESULT : S_DRAIN;
      end
      S_RESULT: nxt = bus.res_ready ? S_IDLE : S_RESULT;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      ovf <= 1'b0;
      err <= ERR_OK;
      res_q <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE) begin
        ovf <= 1'b0;
        err <= ERR_OK;
      end
      if (state == S_EXEC) ovf <= ovf | alu_ovf;
      if (set_err) err <= err_code;
      if (state == S_CAPTURE) res_q <= alu_result;
      if (state == S_DRAIN && depth <= DW'(1)) res_q <= '0;
    end
  assign bus.tok_ready = state == S_ACCEPT;
  assign bus.res_valid = state == S_RESULT;
  assign bus.res_data = res_q;
  assign bus.res_ovf = ovf;
  assign bus.res_err = err;
  a_sp_match: assert property (@(posedge clk) disable iff (!rst)
    state == S_ACCEPT |-> alu_sp == 5'(depth));
endmodule
